// File: rtl/clock_time_keeper.sv
`default_nettype none
// ============================================================================
// Module   : clock_time_keeper
// Brief    : 1 Hz BCD time/date keeper with per-mode digit edits. Defining
//            ALARM_EN builds the alarm registers, arming and ring logic.
// Revision : 1.0 - initial release
// ============================================================================
module clock_time_keeper #(
    parameter int MFREQ_KHZ = 1
) (
    input  logic       mclk,
    input  logic       rst,
    input  logic [1:0] clk_mode,
    input  logic [1:0] vButton,
    output logic [7:0] hour,
    output logic [7:0] minute,
    output logic [7:0] second,
    output logic [7:0] day,
    output logic [7:0] month,
    output logic [7:0] alarm_hour,
    output logic [7:0] alarm_minute,
    output logic       alarm_ring,
    output logic       sec_tick
);

    localparam logic [1:0]  c_MODE_TIME = 2'd1;
    localparam logic [1:0]  c_MODE_DATE = 2'd3;
    localparam logic [31:0] c_TERMINAL  = 32'(MFREQ_KHZ * 1000 - 1);

    function automatic logic [7:0] bcdInc(input logic [7:0] v);
        return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : v + 8'd1;
    endfunction

    function automatic logic [7:0] bcdWrapInc(input logic [7:0] v,
                                              input logic [7:0] top,
                                              input logic [7:0] bottom);
        return (v >= top) ? bottom : bcdInc(v);
    endfunction

    function automatic logic [7:0] monthLen(input logic [7:0] m);
        case (m)
            8'h02:                      return 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
            default:                    return 8'h31;
        endcase
    endfunction

    logic [31:0] r_presc;
    logic        w_tick;
    logic        w_midnight;
    logic [7:0]  w_sec;
    logic [7:0]  w_min;
    logic [7:0]  w_hour;
    logic [7:0]  w_day;
    logic [7:0]  w_mon;

    always_comb begin
        w_tick     = (clk_mode != c_MODE_TIME) && (r_presc == c_TERMINAL);
        w_midnight = 1'b0;
        w_sec      = second;
        w_min      = minute;
        w_hour     = hour;
        w_day      = day;
        w_mon      = month;
        if (clk_mode == c_MODE_TIME) begin
            w_sec = 8'h00;
            if (vButton[0]) w_min  = bcdWrapInc(minute, 8'h59, 8'h00);
            if (vButton[1]) w_hour = bcdWrapInc(hour,   8'h23, 8'h00);
        end else begin
            if (clk_mode == c_MODE_DATE) begin
                // Day edit wraps on the current month; a month edit then clamps it.
                if (vButton[0]) w_day = bcdWrapInc(day, monthLen(month), 8'h01);
                if (vButton[1]) begin
                    w_mon = bcdWrapInc(month, 8'h12, 8'h01);
                    if (w_day > monthLen(w_mon)) w_day = monthLen(w_mon);
                end
            end
            if (w_tick) begin
                w_sec = bcdWrapInc(second, 8'h59, 8'h00);
                if (second == 8'h59) begin
                    w_min = bcdWrapInc(minute, 8'h59, 8'h00);
                    if (minute == 8'h59) begin
                        w_hour     = bcdWrapInc(hour, 8'h23, 8'h00);
                        w_midnight = (hour == 8'h23);
                    end
                end
            end
            // Midnight carry lands on top of any date edit from this same edge.
            if (w_midnight) begin
                w_day = bcdWrapInc(w_day, monthLen(w_mon), 8'h01);
                if (w_day == 8'h01) w_mon = bcdWrapInc(w_mon, 8'h12, 8'h01);
            end
        end
    end

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            r_presc  <= '0;
            sec_tick <= 1'b0;
            hour     <= 8'h00;
            minute   <= 8'h00;
            second   <= 8'h00;
            day      <= 8'h01;
            month    <= 8'h01;
        end else begin
            r_presc  <= (clk_mode == c_MODE_TIME || w_tick) ? '0 : r_presc + 32'd1;
            sec_tick <= w_tick;
            hour     <= w_hour;
            minute   <= w_min;
            second   <= w_sec;
            day      <= w_day;
            month    <= w_mon;
        end
    end

`ifdef ALARM_EN
    localparam logic [1:0] c_MODE_RUN   = 2'd0;
    localparam logic [1:0] c_MODE_ALARM = 2'd2;

    logic [1:0] r_prevMode;
    logic       r_armed;
    logic       w_minInc;
    logic       w_ringSet;

    assign w_minInc  = w_tick && (second == 8'h59);
    assign w_ringSet = (clk_mode == c_MODE_RUN) && r_armed && w_minInc &&
                       (w_min == alarm_minute) && (w_hour == alarm_hour);

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            r_prevMode   <= c_MODE_RUN;
            r_armed      <= 1'b0;
            alarm_hour   <= 8'h00;
            alarm_minute <= 8'h00;
            alarm_ring   <= 1'b0;
        end else begin
            r_prevMode <= clk_mode;
            if (r_prevMode == c_MODE_ALARM && clk_mode == c_MODE_RUN) r_armed <= 1'b1;
            if (clk_mode == c_MODE_ALARM) begin
                if (vButton[0]) alarm_minute <= bcdWrapInc(alarm_minute, 8'h59, 8'h00);
                if (vButton[1]) alarm_hour   <= bcdWrapInc(alarm_hour,   8'h23, 8'h00);
            end
            // A press or mode change silences the ring even on the matching tick.
            if (vButton != 2'b00 || clk_mode != r_prevMode) alarm_ring <= 1'b0;
            else if (w_ringSet)                               alarm_ring <= 1'b1;
            else if (w_minInc)                                alarm_ring <= 1'b0;
        end
    end
`else
    assign alarm_hour   = 8'h00;
    assign alarm_minute = 8'h00;
    assign alarm_ring   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clock_time_keeper.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_time_keeper
// Brief    : Self-checking bench: integer time-of-day reference model compared
//            every cycle, directed scenarios plus randomized mode/button traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_time_keeper;

    localparam int MFREQ_KHZ = 1;
    localparam int PERIOD    = MFREQ_KHZ * 1000;
`ifdef ALARM_EN
    localparam bit ALARM = 1'b1;
`else
    localparam bit ALARM = 1'b0;
`endif

    logic       mclk;
    logic       rst;
    logic [1:0] mode;
    logic [1:0] btn;
    logic [7:0] hour, minute, second, day, month, alarmHour, alarmMinute;
    logic       alarmRing, secTick;

    clock_time_keeper #(.MFREQ_KHZ(MFREQ_KHZ)) dut (
        .mclk        (mclk),
        .rst         (rst),
        .clk_mode    (mode),
        .vButton     (btn),
        .hour        (hour),
        .minute      (minute),
        .second      (second),
        .day         (day),
        .month       (month),
        .alarm_hour  (alarmHour),
        .alarm_minute(alarmMinute),
        .alarm_ring  (alarmRing),
        .sec_tick    (secTick)
    );

    initial begin
        mclk = 1'b0;
        forever #5 mclk = ~mclk;
    end

    int nChecks  = 0;
    int nPass    = 0;
    int tickSeen = 0;
    bit checkOn  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    endtask

    // Reference model: plain integers, carries via seconds-of-day arithmetic.
    int mlen [12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    int mH = 0, mM = 0, mS = 0, mD = 1, mMo = 1, mAh = 0, mAm = 0, mPresc = 0;
    bit mRing = 1'b0, mTick = 1'b0;
`ifdef ALARM_EN
    bit mArmed = 1'b0;
    int mPrevMode = 0;
`endif

    function automatic logic [7:0] toBcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic modelReset();
        mH = 0; mM = 0; mS = 0; mD = 1; mMo = 1; mAh = 0; mAm = 0;
        mPresc = 0; mRing = 1'b0; mTick = 1'b0;
`ifdef ALARM_EN
        mArmed = 1'b0; mPrevMode = 0;
`endif
    endtask

    task automatic modelStep(input int m, input logic [1:0] b);
        int nh, nm, ns, nd, nmo, sod;
        bit tick, minuteInc;
        tick      = (m != 1) && (mPresc == PERIOD - 1);
        mPresc    = (m == 1 || tick) ? 0 : mPresc + 1;
        nh = mH; nm = mM; ns = mS; nd = mD; nmo = mMo;
        minuteInc = 1'b0;
        if (m == 1) begin
            ns = 0;
            if (b[0]) nm = (mM + 1) % 60;
            if (b[1]) nh = (mH + 1) % 24;
        end else begin
            if (m == 3) begin
                if (b[0]) nd = mD % mlen[mMo-1] + 1;
                if (b[1]) begin
                    nmo = mMo % 12 + 1;
                    if (nd > mlen[nmo-1]) nd = mlen[nmo-1];
                end
            end
            if (tick) begin
                sod       = mH * 3600 + mM * 60 + mS + 1;
                minuteInc = (sod % 60 == 0);
                if (sod == 86400) begin
                    sod = 0;
                    if (nd == mlen[nmo-1]) begin
                        nd  = 1;
                        nmo = nmo % 12 + 1;
                    end else begin
                        nd++;
                    end
                end
                nh = sod / 3600;
                nm = (sod / 60) % 60;
                ns = sod % 60;
            end
        end
`ifdef ALARM_EN
        if (b != 2'b00 || m != mPrevMode)                              mRing = 1'b0;
        else if (m == 0 && mArmed && minuteInc && nm == mAm && nh == mAh) mRing = 1'b1;
        else if (minuteInc)                                              mRing = 1'b0;
        if (m == 2) begin
            if (b[0]) mAm = (mAm + 1) % 60;
            if (b[1]) mAh = (mAh + 1) % 24;
        end
        if (mPrevMode == 2 && m == 0) mArmed = 1'b1;
        mPrevMode = m;
`endif
        mH = nh; mM = nm; mS = ns; mD = nd; mMo = nmo; mTick = tick;
    endtask

    always @(posedge mclk or posedge rst) begin
        if (rst) modelReset();
        else     modelStep(int'(mode), btn);
    end

    task automatic compareCycle();
        check("cycle",
              {hour, minute, second, day, month, alarmHour, alarmMinute, alarmRing, secTick},
              {toBcd(mH), toBcd(mM), toBcd(mS), toBcd(mD), toBcd(mMo),
               toBcd(mAh), toBcd(mAm), mRing, mTick});
        if (secTick) tickSeen++;
    endtask

    always @(negedge mclk) begin
        if (checkOn) compareCycle();
    end

    task automatic drive(input logic [1:0] m, input logic [1:0] b);
        @(negedge mclk);
        mode = m;
        btn  = b;
    endtask

    task automatic idle(input logic [1:0] m, input int n);
        for (int i = 0; i < n; i++) drive(m, 2'b00);
    endtask

    task automatic pulses(input logic [1:0] m, input logic [1:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            drive(m, b);
            drive(m, 2'b00);
        end
    endtask

    initial begin : p_main
        int cyc;
        int dwell;
        logic [1:0] rm, rb, prevB;
        rst  = 1'b1;
        mode = 2'd0;
        btn  = 2'b00;
        repeat (3) @(negedge mclk);
        check("reset time/date", {hour, minute, second, day, month}, 40'h00_00_00_01_01);
        check("reset alarm/ring/tick", {alarmHour, alarmMinute, alarmRing, secTick}, 18'h0);
        checkOn = 1'b1;
        rst     = 1'b0;

        // First second: tick lands on the 1000th edge after reset release
        idle(2'd0, PERIOD - 1);
        check("pre-tick second", {second, 7'd0, secTick}, 16'h0000);
        idle(2'd0, 1);
        check("first tick time", {hour, minute, second}, 24'h00_00_01);
        check("first tick pulse", secTick, 1'b1);

        // Set-time minute wrap without carry, seconds frozen
        pulses(2'd1, 2'b01, 59);
        check("set minute 59", {hour, minute, second}, 24'h00_59_00);
        pulses(2'd1, 2'b01, 1);
        check("set minute wrap", {hour, minute, second}, 24'h00_00_00);
        check("ticks so far", tickSeen, 1);

        // Date: day 31 in January, then month edit clamps to 28
        pulses(2'd3, 2'b01, 30);
        check("day 31 jan", {day, month}, 16'h31_01);
        pulses(2'd3, 2'b10, 1);
        check("feb clamp", {day, month}, 16'h28_02);

        // Alarm edits and wrap back to 00:00, then arm via 2->0
        pulses(2'd2, 2'b11, 1);
        check("alarm 01:01", {alarmHour, alarmMinute}, ALARM ? 16'h0101 : 16'h0000);
        pulses(2'd2, 2'b11, 23);
        pulses(2'd2, 2'b01, 36);
        check("alarm wrap 00:00", {alarmHour, alarmMinute}, 16'h0000);
        idle(2'd0, 2);

        // 23:59:00 on 28/02, run a full minute to midnight
        pulses(2'd1, 2'b10, 23);
        pulses(2'd1, 2'b01, 59);
        check("preload 23:59", {hour, minute, second}, 24'h23_59_00);
        drive(2'd0, 2'b00);
        idle(2'd0, 60 * PERIOD - 1);
        check("23:59:59", {hour, minute, second, day, month}, 40'h23_59_59_28_02);
        idle(2'd0, 1);
        check("midnight rollover", {hour, minute, second, day, month}, 40'h00_00_00_01_03);
        check("midnight tick", secTick, 1'b1);
        check("alarm rings", alarmRing, ALARM);
        idle(2'd0, 1);
        check("alarm holds", alarmRing, ALARM);
        pulses(2'd0, 2'b01, 1);
        check("alarm press clear", alarmRing, 1'b0);

        // Randomized modes and button pulses
        cyc   = 0;
        prevB = 2'b00;
        while (cyc < 8000) begin
            rm    = 2'($urandom_range(0, 3));
            dwell = $urandom_range(1, 60);
            for (int k = 0; k < dwell; k++) begin
                rb = (prevB == 2'b00 && $urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                drive(rm, rb);
                prevB = rb;
                cyc++;
            end
        end
        drive(2'd0, 2'b00);

        // Asynchronous reset between clock edges
        idle(2'd0, 437);
        @(negedge mclk);
        #2 rst = 1'b1;
        #1;
        check("async reset",
              {hour, minute, second, day, month, alarmHour, alarmMinute, alarmRing, secTick},
              {8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0});
        repeat (3) @(negedge mclk);
        rst = 1'b0;
        idle(2'd0, 20);
        check("post-reset run", {hour, minute, second, day, month}, 40'h00_00_00_01_01);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
